// File: rtl/alu_pkg.sv
// Shared op codes, engine state encoding and constants for the multi-cycle ALU.
package alu_pkg;

  localparam logic [4:0] OP_ADD    = 5'b0_0000;
  localparam logic [4:0] OP_SUB    = 5'b0_0001;
  localparam logic [4:0] OP_AND    = 5'b0_0010;
  localparam logic [4:0] OP_OR     = 5'b0_0011;
  localparam logic [4:0] OP_XOR    = 5'b0_0100;
  localparam logic [4:0] OP_SLT    = 5'b0_0101;
  localparam logic [4:0] OP_SLTU   = 5'b0_0110;
  localparam logic [4:0] OP_SLL    = 5'b0_0111;
  localparam logic [4:0] OP_SRL    = 5'b0_1000;
  localparam logic [4:0] OP_SRA    = 5'b0_1001;
  localparam logic [4:0] OP_MUL    = 5'b1_0000;
  localparam logic [4:0] OP_MULH   = 5'b1_0001;
  localparam logic [4:0] OP_MULHSU = 5'b1_0010;
  localparam logic [4:0] OP_MULHU  = 5'b1_0011;
  localparam logic [4:0] OP_DIV    = 5'b1_0100;
  localparam logic [4:0] OP_DIVU   = 5'b1_0101;
  localparam logic [4:0] OP_REM    = 5'b1_0110;
  localparam logic [4:0] OP_REMU   = 5'b1_0111;

  localparam logic [31:0] DEADBEEF = 32'hDEADBEEF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_FIX
  } md_state_e;

endpackage

// File: rtl/muldiv_seq.sv
// Iterative multiply/divide engine on operand magnitudes with a final sign fix-up.
module muldiv_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             go,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] ma,
  input  logic [WIDTH-1:0] mb,
  input  logic             neg,
  output logic             fin,
  output logic [WIDTH-1:0] res
);

  localparam int CW = $clog2(WIDTH);

  md_state_e          state, state_nxt;
  logic [CW-1:0]      cnt, cnt_dec;
  logic [WIDTH-1:0]   ma_q, mb_q;
  logic [2:0]         op_q;
  logic               neg_q;
  logic [2*WIDTH-1:0] acc, mul_step, prod_fix;
  logic [WIDTH-1:0]   quo, rem, quo_step, rem_step, quo_fix, rem_fix;
  logic               idle, ge;
  logic [WIDTH-1:0]   op_a, op_b, mul_hi_src, mul_lo_src, rem_src, quo_src;
  logic [WIDTH:0]     mul_sum, r2;

  assign idle    = (state == ST_IDLE);
  assign cnt_dec = cnt - 1'b1;

  // The first step runs on the launch edge straight from the inputs, so the
  // counter (loaded with WIDTH-1) only has to cover the remaining steps.
  always_comb begin
    op_a       = idle ? ma : ma_q;
    op_b       = idle ? mb : mb_q;
    mul_hi_src = idle ? '0 : acc[2*WIDTH-1:WIDTH];
    mul_lo_src = idle ? mb : acc[WIDTH-1:0];
    mul_sum    = {1'b0, mul_hi_src} + (mul_lo_src[0] ? {1'b0, op_a} : '0);
    mul_step   = {mul_sum, mul_lo_src[WIDTH-1:1]};
    rem_src    = idle ? '0 : rem;
    quo_src    = idle ? ma : quo;
    r2         = {rem_src, quo_src[WIDTH-1]};
    ge         = (r2 >= {1'b0, op_b});
    rem_step   = ge ? WIDTH'(r2 - {1'b0, op_b}) : WIDTH'(r2);
    quo_step   = {quo_src[WIDTH-2:0], ge};
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (go) state_nxt = op[2] ? ST_DIV : ST_MUL;
      ST_MUL,
      ST_DIV:  if (cnt_dec == '0) state_nxt = ST_FIX;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt   <= '0;
      ma_q  <= '0;
      mb_q  <= '0;
      op_q  <= '0;
      neg_q <= 1'b0;
      acc   <= '0;
      quo   <= '0;
      rem   <= '0;
    end else begin
      case (state)
        ST_IDLE: if (go) begin
          ma_q  <= ma;
          mb_q  <= mb;
          op_q  <= op;
          neg_q <= neg;
          cnt   <= CW'(WIDTH - 1);
          if (op[2]) begin
            quo <= quo_step;
            rem <= rem_step;
          end else begin
            acc <= mul_step;
          end
        end
        ST_MUL: begin
          acc <= mul_step;
          cnt <= cnt_dec;
        end
        ST_DIV: begin
          quo <= quo_step;
          rem <= rem_step;
          cnt <= cnt_dec;
        end
        default: ;
      endcase
    end
  end

  assign fin = (state == ST_FIX);

  always_comb begin
    prod_fix = neg_q ? -acc : acc;
    quo_fix  = neg_q ? -quo : quo;
    rem_fix  = neg_q ? -rem : rem;
    case (op_q[2:1])
      2'b00:   res = op_q[0] ? prod_fix[2*WIDTH-1:WIDTH] : prod_fix[WIDTH-1:0];
      2'b01:   res = prod_fix[2*WIDTH-1:WIDTH];
      2'b10:   res = quo_fix;
      default: res = rem_fix;
    endcase
  end

endmodule

// File: rtl/mc_alu.sv
// Execute-stage ALU: registered single-cycle RV32I ops, iterative RV32M ops.
module mc_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [4:0]       alu_ctrl,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero
);

  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [63:0]      BAD64   = {32'h0, DEADBEEF};
  localparam logic [WIDTH-1:0] BAD     = BAD64[WIDTH-1:0];

  logic             accept, is_iter, is_div, is_rem, a_sgn, b_sgn, a_neg, b_neg;
  logic             md_neg, div_zero, div_ovf, special, go, fin;
  logic [WIDTH-1:0] mag_a, mag_b, sc_res, md_res;
  logic [SHW-1:0]   sh;

  assign sh      = b[SHW-1:0];
  assign accept  = start & ~busy;
  assign is_iter = alu_ctrl inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU,
                                    OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  assign is_div  = alu_ctrl inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  assign is_rem  = alu_ctrl inside {OP_REM, OP_REMU};
  assign a_sgn   = alu_ctrl inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  assign b_sgn   = alu_ctrl inside {OP_MULH, OP_DIV, OP_REM};
  assign a_neg   = a_sgn & a[WIDTH-1];
  assign b_neg   = b_sgn & b[WIDTH-1];
  assign mag_a   = a_neg ? -a : a;
  assign mag_b   = b_neg ? -b : b;
  // Remainder follows the dividend; products and quotients use a^b.
  assign md_neg  = (alu_ctrl == OP_REM) ? a_neg : (a_neg ^ b_neg);

  assign div_zero = is_div & (b == '0);
  assign div_ovf  = ((alu_ctrl == OP_DIV) || (alu_ctrl == OP_REM)) &&
                    (a == MIN_VAL) && (b == '1);
  assign special  = is_iter & (div_zero | div_ovf);
  assign go       = accept & is_iter & ~special;

  always_comb begin
    sc_res = BAD;
    case (alu_ctrl)
      OP_ADD:  sc_res = a + b;
      OP_SUB:  sc_res = a - b;
      OP_AND:  sc_res = a & b;
      OP_OR:   sc_res = a | b;
      OP_XOR:  sc_res = a ^ b;
      OP_SLT:  sc_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: sc_res = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_SLL:  sc_res = a << sh;
      OP_SRL:  sc_res = a >> sh;
      OP_SRA:  sc_res = $unsigned($signed(a) >>> sh);
      default: begin
        if (div_zero)     sc_res = is_rem ? a : '1;
        else if (div_ovf) sc_res = is_rem ? '0 : MIN_VAL;
      end
    endcase
  end

  muldiv_seq #(
    .WIDTH(WIDTH)
  ) u_muldiv (
    .clk   (clk),
    .reset (reset),
    .go    (go),
    .op    (alu_ctrl[2:0]),
    .ma    (mag_a),
    .mb    (mag_b),
    .neg   (md_neg),
    .fin   (fin),
    .res   (md_res)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      zero   <= 1'b1;
    end else begin
      done <= 1'b0;
      if (fin) begin
        busy   <= 1'b0;
        done   <= 1'b1;
        result <= md_res;
        zero   <= (md_res == '0);
      end else if (accept) begin
        if (go) begin
          busy <= 1'b1;
        end else begin
          done   <= 1'b1;
          result <= sc_res;
          zero   <= (sc_res == '0);
        end
      end
    end
  end

endmodule

// File: doc/mc_alu.md
# mc_alu

Multi-cycle, parametrised successor to the single-cycle ALU in the RISC-V core. Executes the RV32I integer ops in one registered cycle and the RV32M multiply/divide ops with an iterative WIDTH-step engine behind a start/busy/done handshake. Sits in the execute stage; the control unit stalls PC and register-file writes while `busy` is high.

## Interface
- `WIDTH`, 32, operand/result width; power of two, 8 to 64.
- `SHW`, $clog2(WIDTH), shift-amount width taken from `b[SHW-1:0]`.
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  reset; synchronous, active-high.
- `start`  in  1  request; sampled only while `busy`=0.
- `alu_ctrl`  in  5  operation code, sampled with `start`.
- `a`, `b`  in  WIDTH  operands, sampled with `start`.
- `busy`  out  1  operation in flight; new `start` ignored.
- `done`  out  1  single-cycle pulse; `result` valid from this cycle.
- `result`  out  WIDTH  registered result; held until the next `done`.
- `zero`  out  1  registered `result == 0`.

## Operation
- Codes 0_0000 to 0_1001 are single-cycle: ADD, SUB, AND, OR, XOR, SLT, SLTU, SLL, SRL, SRA.
  - SLT is a true two's-complement signed compare.
  - SRA is an arithmetic right shift.
- Codes 1_0000 to 1_0111 are iterative: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
  - MUL returns the low WIDTH bits of the product.
  - MULH, MULHSU and MULHU return the high WIDTH bits of the 2·WIDTH product.
  - MULH treats a and b as signed; MULHSU treats a as signed and b as unsigned; MULHU treats both as unsigned.
- Any other code completes as a single-cycle op with result = 32'hDEADBEEF (truncated or zero-extended to WIDTH).
- Iterative engine:
  - Operands are latched as magnitudes, together with the result sign.
  - Multiply is shift-add into a 2·WIDTH accumulator.
  - Divide is restoring: one quotient bit per cycle, giving quotient and remainder registers.
  - The fix-up state negates the result when the sign flag is set.
  - The DIV quotient sign is a^b; the REM remainder takes the sign of the dividend.
- Divide special cases take the single-cycle path:
  - Divide by zero (b=0): DIV and DIVU return all ones; REM and REMU return a.
  - Signed overflow (a=MIN, b=−1): DIV returns MIN; REM returns 0.
- FSM states: IDLE, MUL, DIV, FIX.
  - IDLE to MUL or DIV on `start` with an iterative code that is not a special case; the counter loads WIDTH−1.
  - MUL or DIV decrements the counter each cycle; at counter 0 the FSM goes to FIX.
  - FIX writes `result`, pulses `done` and returns to IDLE.
  - Single-cycle ops stay in IDLE: `result` and `done` update on the edge that samples `start`.
- `zero` is always updated on the same edge as `result`.

## Timing
- Reset values: FSM IDLE, `busy`=0, `done`=0, `result`=0, `zero`=1, counter=0, accumulators=0.
- Single-cycle ops: `start` sampled at edge N; `done`=1 and `result` valid during cycle N+1; `busy` stays 0.
  - Back-to-back `start` every cycle is legal, giving one result per cycle.
- Iterative ops: `start` sampled at edge N.
  - `busy`=1 from cycle N+1.
  - WIDTH iteration edges follow, then FIX.
  - `done`=1 during cycle N+WIDTH+1 (33 cycles for WIDTH=32).
  - `busy` drops in the same cycle `done` rises.
  - A new `start` is accepted in that `done` cycle.
- `start` while `busy`=1 is ignored and has no effect on in-flight state.
- `reset` mid-operation:
  - Aborts with no `done`.
  - All outputs return to their reset values on that edge.
  - `reset` dominates a simultaneous `start`.
- Operand inputs may change after the sampling edge without effect.

## Structure
- Package `alu_pkg`:
  - op-code localparams (18 legal codes);
  - FSM state encoding;
  - the DEADBEEF constant.
- Sub-module `muldiv_seq`:
  - iterative engine: counter, accumulator, quotient and remainder registers, and the FIX sign fix-up;
  - handshake is `go`, `op[2:0]`, magnitudes plus sign flag in, `fin`, `res` out.
- `mc_alu` holds:
  - the single-cycle datapath;
  - special-case detection;
  - the output registers and the `busy`/`done` logic.

## Test plan
- After reset: `result`=0, `zero`=1, `busy`=0. Then ADD 7+(−3) gives `result`=4 one cycle later. Then SUB 5−5 gives `result`=0, `zero`=1. Then SLT −1,1 gives 1. Then SLTU −1,1 gives 0. Then SRA 0x80000000 by 4 gives 0xF8000000.
- Each of MUL, MULH, MULHSU and MULHU with a=−2, b=3:
  - Required results: 0xFFFFFFFA, 0xFFFFFFFF, 0xFFFFFFFF, 0x00000002.
  - Each gives `done` exactly 33 cycles after `start`, with `busy` high for cycles 1–32.
- DIV −7/2 gives −3; REM −7/2 gives −1; DIVU 7/2 gives 3; REMU 7/2 gives 1.
- DIV 5/0 gives 0xFFFFFFFF; REM 5/0 gives 5; DIV 0x80000000/−1 gives 0x80000000; REM of the same gives 0. All four give `done` after 1 cycle.
- Start DIVU, then pulse `start` with an ADD at cycle 10 and expect the ADD to be ignored. Assert `reset` at cycle 20 and expect no `done`, all outputs reset and an immediate new MUL to succeed.
- Undefined code 1_1000 gives 0xDEADBEEF after 1 cycle.
